host_request_frontend: RTL and testbench
========================================

Name: host_request_frontend

Overview:
- Host-facing responder for the memory controller request interface.
- Accepts write and read requests from the host over the in_valid/out_busy handshake and queues them.
- Hands queued requests in order to the back-end scheduler over a valid/ready port.
- Buffers in-order read data from the back-end and returns it to the host as data_out with a read_done pulse; pulses write_done when a write is handed off.

Parameters:
DATA_WIDTH, 16, host data width
ADDR_WIDTH, 30, host address width
REQ_DEPTH, 8, request FIFO entries (power of 2)
RD_DEPTH, 8, max reads accepted but not yet returned to host (power of 2)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  host request present
in_request_type  in  1  1=write, 0=read
in_request_address  in  ADDR_WIDTH  request address
in_request_data  in  DATA_WIDTH  write data (ignored for reads)
out_busy  out  1  request will not be accepted this cycle
write_done  out  1  1-cycle pulse per write handed to back-end
read_done  out  1  1-cycle pulse, data_out valid
data_out  out  DATA_WIDTH  read data
be_valid  out  1  back-end request valid
be_ready  in  1  back-end accepts request
be_type  out  1  request type at FIFO head
be_address  out  ADDR_WIDTH  address at FIFO head
be_data  out  DATA_WIDTH  write data at FIFO head
be_rd_valid  in  1  back-end read data valid, in request order
be_rd_data  in  DATA_WIDTH  back-end read data
protocol_err  out  1  sticky: be_rd_valid with no outstanding read

Behaviour:
- Reset (rst_n low, async): FIFOs emptied, counters zero; write_done, read_done, be_valid, protocol_err = 0; data_out = 0; out_busy = 1 while rst_n low.
- out_busy is combinational from registered state: req_count == REQ_DEPTH, or (in_request_type==0 and rd_credit == RD_DEPTH). Writes are never blocked by read credit.
- Accept: in_valid && !out_busy at posedge. The request pushes {type, addr, data}. Requests presented while busy are ignored; the host must re-present them.
- rd_credit: +1 per accepted read, -1 per read_done; both events in the same cycle leave it unchanged.
- be_valid = request FIFO not empty. be_type/be_address/be_data show the head entry and stay stable until be_ready. A pop occurs on be_valid && be_ready.
- Latency: a request accepted at edge t is visible on be_* after edge t; earliest pop is at edge t+1. No bypass of an empty FIFO.
- write_done: registered, asserted the cycle after a write pops.
- Read return: be_rd_valid pushes be_rd_data into the response FIFO (RD_DEPTH entries; cannot overflow because of rd_credit). At most one pop per cycle. read_done and data_out are registered: data received at edge t is output after edge t+1 if the FIFO was empty. data_out holds its last value between pulses.
- Push and pop on the same cycle, for either FIFO, at any occupancy including full: count unchanged, data order preserved. out_busy reflects the pre-edge count, so a full FIFO stays busy that cycle even while popping.
- Pointers wrap modulo depth; full and empty are distinguished by count.
- protocol_err sets when be_rd_valid arrives with rd_credit == reads already buffered (no outstanding read). The data is dropped, and the flag clears only on reset.
- Reset mid-operation: all queued requests and buffered data are discarded, with no done pulses.

Test Plan:
- Reset: hold rst_n low 100 cycles -> out_busy=1, all other outputs 0. Release -> out_busy=0 on the next cycle.
- Fill: be_ready=0, present writes at addr 0..8, data=addr -> 8 accepted, out_busy=1, 9th ignored. Set be_ready=1 -> be_address 0..7 in order, 8 write_done pulses each one cycle after its pop, out_busy drops after the first pop.
- Read data: 4 reads at addr 0..3, back-end returns 0x00A0..0x00A3 on consecutive cycles -> read_done on 4 consecutive cycles starting one cycle after the first be_rd_valid, data_out 0x00A0..0x00A3 in order.
- Credit: be_ready=1, 8 reads, no return -> out_busy=1 for a read while req FIFO is empty; a write is still accepted. One be_rd_valid -> read_done, then a read is accepted.
- Simultaneous: full request FIFO, be_ready=1 and in_valid=1 -> head pops, new request ignored (busy), count=7. Next cycle a push plus pop leaves count 7 and order is intact.
- Spurious return: be_rd_valid with no outstanding reads -> protocol_err=1, no read_done. It stays 1 until rst_n low.

Source files
------------

// File: rtl/host_request_frontend.sv
// Purpose: host request queue + in-order read-return buffer in front of the memory back-end scheduler.
// Latency: request visible on be_* one edge after accept; read data on data_out one edge after it is buffered.
// Backpressure: out_busy on full request queue or exhausted read credit; back-end stalls the queue with be_ready.

// Purpose: generic circular FIFO storing W-bit words, head word always presented on pop_dat.
// Latency: a word pushed at edge t is at the head after edge t (no bypass when empty).
// Backpressure: none internally; the caller must not push when full unless popping in the same cycle.
module hrf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage array: data only, no reset needed since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally (power-of-2 depth); count tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

// Purpose: accept host reads/writes, forward them in order to the back-end, return read data with read_done.
// Latency: accept at t -> be_valid after t; be_rd_valid at t -> read_done/data_out after t+1 when buffer empty.
// Backpressure: out_busy when request queue full, or for reads when RD_DEPTH reads are outstanding.
module host_request_frontend #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 30,
    parameter int REQ_DEPTH  = 8,
    parameter int RD_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_request_type,
    input  logic [ADDR_WIDTH-1:0] in_request_address,
    input  logic [DATA_WIDTH-1:0] in_request_data,
    output logic                  out_busy,
    output logic                  write_done,
    output logic                  read_done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  be_valid,
    input  logic                  be_ready,
    output logic                  be_type,
    output logic [ADDR_WIDTH-1:0] be_address,
    output logic [DATA_WIDTH-1:0] be_data,
    input  logic                  be_rd_valid,
    input  logic [DATA_WIDTH-1:0] be_rd_data,
    output logic                  protocol_err
);
    localparam int QCW = $clog2(REQ_DEPTH) + 1;
    localparam int RCW = $clog2(RD_DEPTH) + 1;

    typedef struct packed {
        logic                  is_wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } req_t;

    req_t           req_in;
    req_t           req_head;
    logic [QCW-1:0] req_count;
    logic           req_push;
    logic           req_pop;

    logic [DATA_WIDTH-1:0] rsp_head;
    logic [RCW-1:0]        rsp_count;
    logic                  rsp_push;
    logic                  rsp_pop;
    logic                  rd_spurious;

    // Reads accepted but not yet handed back to the host (buffered ones included).
    logic [RCW-1:0] rd_credit;
    logic           accept_rd;

    // Busy is decided from pre-edge counts so a full queue stays busy even while it pops.
    assign out_busy  = !rst_n
                     || (req_count == QCW'(REQ_DEPTH))
                     || (!in_request_type && (rd_credit == RCW'(RD_DEPTH)));
    assign req_push  = in_valid && !out_busy;
    assign accept_rd = req_push && !in_request_type;
    assign req_in    = '{is_wr: in_request_type, addr: in_request_address, dat: in_request_data};

    assign be_valid   = (req_count != '0);
    assign req_pop    = be_valid && be_ready;
    assign be_type    = req_head.is_wr;
    assign be_address = req_head.addr;
    assign be_data    = req_head.dat;

    // Return data with no outstanding read (every credited read already buffered) is dropped.
    assign rd_spurious = be_rd_valid && (rd_credit == rsp_count);
    assign rsp_push    = be_rd_valid && !rd_spurious;
    assign rsp_pop     = (rsp_count != '0);

    hrf_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (req_push),
        .push_dat (req_in),
        .pop      (req_pop),
        .pop_dat  (req_head),
        .count    (req_count)
    );

    hrf_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (RD_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rsp_push),
        .push_dat (be_rd_data),
        .pop      (rsp_pop),
        .pop_dat  (rsp_head),
        .count    (rsp_count)
    );

    // Read credit: up on accepted read, down when a buffered read is returned to the host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_credit <= '0;
        end else begin
            case ({accept_rd, rsp_pop})
                2'b10:   rd_credit <= rd_credit + 1'b1;
                2'b01:   rd_credit <= rd_credit - 1'b1;
                default: rd_credit <= rd_credit;
            endcase
        end
    end

    // Host-side completion pulses, returned data register and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_done   <= 1'b0;
            read_done    <= 1'b0;
            data_out     <= '0;
            protocol_err <= 1'b0;
        end else begin
            write_done   <= req_pop && req_head.is_wr;
            read_done    <= rsp_pop;
            if (rsp_pop) begin
                data_out <= rsp_head;
            end
            protocol_err <= protocol_err || rd_spurious;
        end
    end
endmodule

// File: tb/tb_host_request_frontend.sv
// Purpose: directed self-checking bench for host_request_frontend with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 time unit after each rising clk edge.
// Backpressure: exercises full request queue, exhausted read credit and back-end stalls.
module tb_host_request_frontend;
    localparam int DW = 16;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_request_type;
    logic [AW-1:0] in_request_address;
    logic [DW-1:0] in_request_data;
    logic          out_busy;
    logic          write_done;
    logic          read_done;
    logic [DW-1:0] data_out;
    logic          be_valid;
    logic          be_ready;
    logic          be_type;
    logic [AW-1:0] be_address;
    logic [DW-1:0] be_data;
    logic          be_rd_valid;
    logic [DW-1:0] be_rd_data;
    logic          protocol_err;

    int checks = 0;
    int errors = 0;

    host_request_frontend #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .REQ_DEPTH  (8),
        .RD_DEPTH   (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_request_type    (in_request_type),
        .in_request_address (in_request_address),
        .in_request_data    (in_request_data),
        .out_busy           (out_busy),
        .write_done         (write_done),
        .read_done          (read_done),
        .data_out           (data_out),
        .be_valid           (be_valid),
        .be_ready           (be_ready),
        .be_type            (be_type),
        .be_address         (be_address),
        .be_data            (be_data),
        .be_rd_valid        (be_rd_valid),
        .be_rd_data         (be_rd_data),
        .protocol_err       (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] dat);
        in_valid           = 1'b1;
        in_request_type    = wr;
        in_request_address = addr;
        in_request_data    = dat;
    endtask

    initial begin
        rst_n              = 1'b0;
        in_valid           = 1'b0;
        in_request_type    = 1'b0;
        in_request_address = '0;
        in_request_data    = '0;
        be_ready           = 1'b0;
        be_rd_valid        = 1'b0;
        be_rd_data         = '0;

        // ---------------- reset ----------------
        repeat (100) tick();
        check("rst_busy",     {31'd0, out_busy},     32'd1);
        check("rst_be_valid", {31'd0, be_valid},     32'd0);
        check("rst_wdone",    {31'd0, write_done},   32'd0);
        check("rst_rdone",    {31'd0, read_done},    32'd0);
        check("rst_data_out", {16'd0, data_out},     32'd0);
        check("rst_perr",     {31'd0, protocol_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_busy", {31'd0, out_busy}, 32'd0);

        // ---------------- fill request queue ----------------
        for (int i = 0; i < 9; i++) begin
            host_req(1'b1, AW'(i), DW'(i));
            #1;
            check($sformatf("fill_busy%0d", i), {31'd0, out_busy}, (i < 8) ? 32'd0 : 32'd1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("fill_full_busy", {31'd0, out_busy},   32'd1);
        check("fill_head",      {2'd0, be_address}, 32'd0);
        check("fill_no_wdone",  {31'd0, write_done}, 32'd0);
        be_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_addr%0d", k), {2'd0, be_address}, k);
            check($sformatf("drain_data%0d", k), {16'd0, be_data},   k);
            check($sformatf("drain_type%0d", k), {31'd0, be_type},   32'd1);
            tick();
            check($sformatf("drain_wdone%0d", k), {31'd0, write_done}, 32'd1);
            if (k == 0) check("drain_busy_drop", {31'd0, out_busy}, 32'd0);
        end
        check("drain_empty", {31'd0, be_valid}, 32'd0);
        tick();
        check("drain_wdone_end", {31'd0, write_done}, 32'd0);

        // ---------------- read data return ----------------
        for (int i = 0; i < 4; i++) begin
            host_req(1'b0, AW'(i), 16'hFFFF);
            tick();
            check($sformatf("rd_no_wdone%0d", i), {31'd0, write_done}, 32'd0);
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("rd_fwd_empty", {31'd0, be_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            be_rd_valid = 1'b1;
            be_rd_data  = DW'(16'h00A0 + i);
            tick();
            if (i == 0) begin
                check("rd_first_lat", {31'd0, read_done}, 32'd0);
            end else begin
                check($sformatf("rd_done%0d", i - 1), {31'd0, read_done}, 32'd1);
                check($sformatf("rd_data%0d", i - 1), {16'd0, data_out},  32'h00A0 + i - 1);
            end
        end
        be_rd_valid = 1'b0;
        tick();
        check("rd_done3", {31'd0, read_done}, 32'd1);
        check("rd_data3", {16'd0, data_out},  32'h00A3);
        tick();
        check("rd_done_end", {31'd0, read_done}, 32'd0);
        check("rd_hold",     {16'd0, data_out},  32'h00A3);

        // ---------------- read credit ----------------
        for (int i = 0; i < 8; i++) begin
            host_req(1'b0, AW'(16'h40 + i), 16'h0);
            #1;
            check($sformatf("cr_acc_busy%0d", i), {31'd0, out_busy}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("cr_q_empty", {31'd0, be_valid}, 32'd0);
        host_req(1'b0, AW'(16'h50), 16'h0);
        #1;
        check("cr_rd_blocked", {31'd0, out_busy}, 32'd1);
        tick();
        host_req(1'b1, AW'(16'h55), 16'h5555);
        #1;
        check("cr_wr_allowed", {31'd0, out_busy}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("cr_wr_vld",  {31'd0, be_valid},   32'd1);
        check("cr_wr_type", {31'd0, be_type},    32'd1);
        check("cr_wr_addr", {2'd0, be_address}, 32'h55);
        tick();
        check("cr_wr_done", {31'd0, write_done}, 32'd1);
        be_rd_valid = 1'b1;
        be_rd_data  = 16'h1234;
        tick();
        be_rd_valid = 1'b0;
        check("cr_ret_lat", {31'd0, read_done}, 32'd0);
        host_req(1'b0, AW'(16'h77), 16'h0);
        #1;
        check("cr_still_busy", {31'd0, out_busy}, 32'd1);
        tick();
        check("cr_ret_done",  {31'd0, read_done}, 32'd1);
        check("cr_ret_data",  {16'd0, data_out},  32'h1234);
        check("cr_freed",     {31'd0, out_busy},  32'd0);
        tick();
        in_valid = 1'b0;
        check("cr_rd_vld",  {31'd0, be_valid},   32'd1);
        check("cr_rd_type", {31'd0, be_type},    32'd0);
        check("cr_rd_addr", {2'd0, be_address}, 32'h77);
        tick();
        // return the 8 outstanding reads
        for (int i = 0; i < 8; i++) begin
            be_rd_valid = 1'b1;
            be_rd_data  = DW'(i);
            tick();
        end
        be_rd_valid = 1'b0;
        tick();
        check("cr_drain_done", {31'd0, read_done},    32'd1);
        check("cr_drain_data", {16'd0, data_out},     32'd7);
        tick();
        check("cr_drain_end",  {31'd0, read_done},    32'd0);
        check("cr_no_perr",    {31'd0, protocol_err}, 32'd0);

        // ---------------- simultaneous push/pop at full ----------------
        be_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            host_req(1'b1, AW'(16'h100 + i), DW'(16'h200 + i));
            tick();
        end
        host_req(1'b1, AW'(16'h1F0), 16'h03F0);
        be_ready = 1'b1;
        #1;
        check("sim_full_busy", {31'd0, out_busy}, 32'd1);
        tick();
        check("sim_after_pop_busy", {31'd0, out_busy},   32'd0);
        check("sim_head1",          {2'd0, be_address}, 32'h101);
        tick();
        in_valid = 1'b0;
        be_ready = 1'b0;
        #1;
        check("sim_cnt7_busy", {31'd0, out_busy}, 32'd0);
        be_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("sim_order_addr%0d", k), {2'd0, be_address},
                  (k < 6) ? (32'h102 + k) : 32'h1F0);
            check($sformatf("sim_order_data%0d", k), {16'd0, be_data},
                  (k < 6) ? (32'h202 + k) : 32'h3F0);
            tick();
        end
        check("sim_cnt_exact", {31'd0, be_valid}, 32'd0);
        tick();

        // ---------------- spurious read return ----------------
        be_rd_valid = 1'b1;
        be_rd_data  = 16'hDEAD;
        tick();
        be_rd_valid = 1'b0;
        check("sp_perr_set", {31'd0, protocol_err}, 32'd1);
        tick();
        check("sp_no_rdone", {31'd0, read_done},    32'd0);
        check("sp_data_kept", {16'd0, data_out},    32'd7);
        repeat (5) tick();
        check("sp_perr_sticky", {31'd0, protocol_err}, 32'd1);

        // ---------------- reset mid-operation ----------------
        be_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            host_req(1'b1, AW'(16'h300 + i), 16'h0);
            tick();
        end
        in_valid = 1'b0;
        check("mid_queued", {31'd0, be_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {31'd0, out_busy},     32'd1);
        check("mid_rst_vld",   {31'd0, be_valid},     32'd0);
        check("mid_rst_perr",  {31'd0, protocol_err}, 32'd0);
        check("mid_rst_dout",  {16'd0, data_out},     32'd0);
        be_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_vld",   {31'd0, be_valid},   32'd0);
        check("mid_rel_wdone", {31'd0, write_done}, 32'd0);
        check("mid_rel_busy",  {31'd0, out_busy},   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
